alu_issue: RTL

//   Producer side of the ALU control interface: decodes opcode/funct3/funct7[5], selects operands and

---
 rtl/alu_issue_pkg.sv | 29 ++
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue_ctrl_dec.sv | 50 +++++
 rtl/alu_issue.sv | 72 +++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU op codes, RV32I opcode constants and the shared funct3 -> ALU op map
package alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRA, ALU_SRL, ALU_BGE, ALU_BGEU, ALU_BNE
    } alu_ctrl_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // Register and immediate arithmetic share one funct3 map; only the sub/sra selects differ.
    function automatic alu_ctrl_e op_ctrl(logic [2:0] f3, logic sub, logic sra);
        case (f3)
            3'b000:  if (sub) return ALU_SUB; else return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  if (sra) return ALU_SRA; else return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-side offer, alu-side operands and branch redirect of the issue stage
//   master: the issue register (drives in_ready, out_valid, alu_*, illegal, br_*)
//   slave : its environment (drives the instruction, out_ready, branch_cond, flush)
interface alu_issue_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             branch_cond;
    logic             illegal;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;

    modport master (
        input  in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, pc, flush,
               out_ready, branch_cond,
        output in_ready, out_valid, alu_control, alu_a, alu_b, illegal, br_taken, br_target
    );

    modport slave (
        output in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, pc, flush,
               out_ready, branch_cond,
        input  in_ready, out_valid, alu_control, alu_a, alu_b, illegal, br_taken, br_target
    );
endinterface

// File: rtl/alu_issue_ctrl_dec.sv
// alu_issue_ctrl_dec: combinational RV32I opcode/funct3/funct7_5 -> ALU control decode
//   in : opcode, funct3, funct7_5
//   out: alu_control, use_imm (operand b from imm), shamt_imm (b = imm[4:0]), is_branch, illegal
module alu_issue_ctrl_dec
    import alu_issue_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl_e  alu_control,
    output logic       use_imm,
    output logic       shamt_imm,
    output logic       is_branch,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        use_imm     = 1'b0;
        shamt_imm   = 1'b0;
        is_branch   = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP:     alu_control = op_ctrl(funct3, funct7_5, funct7_5);
            OP_IMM: begin
                alu_control = op_ctrl(funct3, 1'b0, funct7_5);
                use_imm     = 1'b1;
                shamt_imm   = funct3[1:0] == 2'b01;
            end
            LOAD, STORE: use_imm = 1'b1;
            BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    3'b000:  alu_control = ALU_SUB;
                    3'b001:  alu_control = ALU_BNE;
                    3'b100:  alu_control = ALU_SLT;
                    3'b101:  alu_control = ALU_BGE;
                    3'b110:  alu_control = ALU_SLTU;
                    3'b111:  alu_control = ALU_BGEU;
                    default: begin
                        is_branch = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: one-entry valid/ready issue register feeding the alu, with registered branch redirect
//   clk, reset : clock and synchronous active-high reset
//   bus        : alu_issue_if.master (instruction offer, alu operands, branch_cond, flush, br_*)
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_issue_if.master bus
);

    alu_ctrl_e        ctrl;
    logic             use_imm, shamt_imm, is_branch, illegal;
    logic             in_ready, fire_in, fire_out, held_branch;
    logic [WIDTH-1:0] b_sel, held_target;

    alu_issue_ctrl_dec u_dec (
        .opcode     (bus.opcode),
        .funct3     (bus.funct3),
        .funct7_5   (bus.funct7_5),
        .alu_control(ctrl),
        .use_imm    (use_imm),
        .shamt_imm  (shamt_imm),
        .is_branch  (is_branch),
        .illegal    (illegal)
    );

    assign in_ready     = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = in_ready;
    assign fire_in      = bus.in_valid & in_ready;
    assign fire_out     = bus.out_valid & bus.out_ready;

    // Immediate shifts keep only shamt so funct7 bits in imm[11:5] never reach the shifter.
    assign b_sel = illegal ? '0 :
                   ~use_imm ? bus.rs2_val :
                   shamt_imm ? {{(WIDTH-5){1'b0}}, bus.imm[4:0]} : bus.imm;

    // The target is kept privately until the branch leaves, so a back-to-back successor
    // cannot overwrite br_target before its redirect pulse is shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.br_taken    <= 1'b0;
            bus.alu_control <= 4'b0000;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.br_target   <= '0;
            held_branch     <= 1'b0;
            held_target     <= '0;
        end else begin
            bus.br_taken <= fire_out & held_branch & bus.branch_cond & ~bus.flush;
            if (fire_out & held_branch & ~bus.flush)
                bus.br_target <= held_target;
            if (bus.flush)
                bus.out_valid <= 1'b0;
            else if (fire_in) begin
                bus.out_valid   <= 1'b1;
                bus.alu_control <= ctrl;
                bus.alu_a       <= illegal ? '0 : bus.rs1_val;
                bus.alu_b       <= b_sel;
                bus.illegal     <= illegal;
                held_branch     <= is_branch;
                held_target     <= bus.pc + bus.imm;
            end else if (fire_out)
                bus.out_valid <= 1'b0;
        end
    end

endmodule
